mdu_sequencer: RTL

//  Iterative RV32M multiply/divide unit and its sequencer, sitting in the EX stage beside the ALU.

---
 rtl/mdu_sequencer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/mdu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mdu_sequencer
// Purpose  : Iterative RV32M multiply/divide unit with EX-stage stall sequencing.
//            Define MDU_FAST_MUL_EN for a single-cycle multiplier on MUL* ops.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            mdu_validE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] srcAE,
    input  logic [XLEN-1:0] srcBE,
    input  logic            kill,
    output logic            stall_mdu,
    output logic            done,
    output logic [XLEN-1:0] resultE,
    output logic            busy
);

    localparam int                  CW       = $clog2(XLEN);
    localparam logic [CW-1:0]       CNT_INIT = CW'(XLEN - 1);
    localparam logic [XLEN-1:0]     MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [2*XLEN-1:0]   acc_q,   acc_d;
    logic [XLEN-1:0]     opb_q,   opb_d;
    logic                sa_q,    sa_d;
    logic                sb_q,    sb_d;
    logic [1:0]          f3_q,    f3_d;
    logic                done_q,  done_d;
    logic [XLEN-1:0]     res_q,   res_d;

    // Operand decode for an op presented in IDLE
    logic                w_a_signed, w_b_signed;
    logic                w_neg_a, w_neg_b;
    logic [XLEN-1:0]     w_mag_a, w_mag_b;
    logic                w_div_zero, w_div_ovf;

    always_comb begin
        if (!funct3E[2]) begin
            w_a_signed = (funct3E[1:0] != 2'b11);
            w_b_signed = !funct3E[1];
        end else begin
            w_a_signed = !funct3E[0];
            w_b_signed = !funct3E[0];
        end
        w_neg_a    = w_a_signed & srcAE[XLEN-1];
        w_neg_b    = w_b_signed & srcBE[XLEN-1];
        w_mag_a    = w_neg_a ? (~srcAE + 1'b1) : srcAE;
        w_mag_b    = w_neg_b ? (~srcBE + 1'b1) : srcBE;
        w_div_zero = (srcBE == {XLEN{1'b0}});
        w_div_ovf  = !funct3E[0] && (srcAE == MIN_VAL) && (&srcBE);
    end

    // Shift-add step: low half holds the unconsumed multiplier bits
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [2*XLEN-1:0]   w_prod_s;
    logic [XLEN-1:0]     w_mul_res;

    always_comb begin
        w_mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
        w_mul_next = {w_mul_sum, acc_q[XLEN-1:1]};
        w_prod_s   = (sa_q ^ sb_q) ? (~w_mul_next + 1'b1) : w_mul_next;
        w_mul_res  = (f3_q == 2'b00) ? w_prod_s[XLEN-1:0] : w_prod_s[2*XLEN-1:XLEN];
    end

    // Restoring divide step: high half is the partial remainder, low half
    // shifts dividend bits out and quotient bits in
    logic [XLEN:0]       w_rem_sh, w_diff;
    logic                w_ge;
    logic [XLEN-1:0]     w_rem_new;
    logic [2*XLEN-1:0]   w_div_next;
    logic [XLEN-1:0]     w_quo_s, w_rem_s, w_div_res;

    always_comb begin
        w_rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        w_diff     = w_rem_sh - {1'b0, opb_q};
        w_ge       = (w_rem_sh >= {1'b0, opb_q});
        w_rem_new  = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
        w_div_next = {w_rem_new, acc_q[XLEN-2:0], w_ge};
        w_quo_s    = (sa_q ^ sb_q) ? (~w_div_next[XLEN-1:0] + 1'b1) : w_div_next[XLEN-1:0];
        w_rem_s    = sa_q ? (~w_div_next[2*XLEN-1:XLEN] + 1'b1) : w_div_next[2*XLEN-1:XLEN];
        w_div_res  = f3_q[1] ? w_rem_s : w_quo_s;
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0]   w_fast_prod, w_fast_s;
    logic [XLEN-1:0]     w_fast_res;

    always_comb begin
        w_fast_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
        w_fast_s    = (w_neg_a ^ w_neg_b) ? (~w_fast_prod + 1'b1) : w_fast_prod;
        w_fast_res  = (funct3E[1:0] == 2'b00) ? w_fast_s[XLEN-1:0] : w_fast_s[2*XLEN-1:XLEN];
    end
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        f3_d    = f3_q;
        done_d  = 1'b0;
        res_d   = res_q;

        case (state_q)
            S_IDLE: begin
                if (mdu_validE && !kill) begin
                    sa_d    = w_neg_a;
                    sb_d    = w_neg_b;
                    f3_d    = funct3E[1:0];
                    acc_d   = {{XLEN{1'b0}}, w_mag_a};
                    opb_d   = w_mag_b;
                    count_d = CNT_INIT;
                    if (!funct3E[2]) begin
`ifdef MDU_FAST_MUL_EN
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        res_d   = w_fast_res;
`else
                        state_d = S_MUL;
`endif
                    end else if (w_div_zero) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        res_d   = funct3E[1] ? srcAE : {XLEN{1'b1}};
                    end else if (w_div_ovf) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        res_d   = funct3E[1] ? {XLEN{1'b0}} : MIN_VAL;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                acc_d = w_mul_next;
                if (count_q == {CW{1'b0}}) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    res_d   = w_mul_res;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            S_DIV: begin
                acc_d = w_div_next;
                if (count_q == {CW{1'b0}}) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    res_d   = w_div_res;
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A flush abandons whatever is in flight and leaves resultE untouched
        if (kill) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= {CW{1'b0}};
            acc_q   <= {(2*XLEN){1'b0}};
            opb_q   <= {XLEN{1'b0}};
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            f3_q    <= 2'b00;
            done_q  <= 1'b0;
            res_q   <= {XLEN{1'b0}};
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            f3_q    <= f3_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    assign stall_mdu = mdu_validE & ~kill & ~rst & (state_q != S_DONE);
    assign done      = done_q;
    assign resultE   = res_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
